// File: rtl/scaler_accumulator.sv
// scaler_accumulator: counts per-channel scaler flags over a gate period and
// latches saturated per-period totals into holding registers read via an addressed port.
`default_nettype none

module scaler_accumulator #(
  parameter int NUM_SCALERS = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_SCALERS-1:0] scaler_i,
  input  logic                   gate_i,
  input  logic                   clear_i,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
  input  logic                   rd_i,
  output logic [COUNT_WIDTH-1:0] rd_data_o,
  output logic                   rd_valid_o,
  output logic                   update_o,
  output logic [NUM_SCALERS-1:0] overflow_o,
  output logic [7:0]             period_count_o
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state, state_next;

  logic latch_en;
  logic acc_clr;
  logic acc_run;

  logic [COUNT_WIDTH-1:0] acc     [NUM_SCALERS];
  logic [COUNT_WIDTH-1:0] acc_inc [NUM_SCALERS];
  logic [COUNT_WIDTH-1:0] holding [NUM_SCALERS];
  logic [NUM_SCALERS-1:0] sat;
  logic [NUM_SCALERS-1:0] sat_hit;
  logic [COUNT_WIDTH-1:0] rd_sel;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counting only starts at the first gate, so IDLE keeps accumulators cleared.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    acc_clr    = 1'b0;
    acc_run    = 1'b0;
    if (clear_i) begin
      state_next = IDLE;
      acc_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          acc_clr = 1'b1;
          if (gate_i) begin
            state_next = COUNT;
          end
        end
        COUNT: begin
          if (gate_i) begin
            latch_en = 1'b1;
            acc_clr  = 1'b1;
          end else begin
            acc_run = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // sat_hit marks a flag that would push a full accumulator past its maximum.
  always_comb begin
    for (int n = 0; n < NUM_SCALERS; n++) begin
      sat_hit[n] = scaler_i[n] && (acc[n] == COUNT_MAX);
      acc_inc[n] = sat_hit[n] ? acc[n]
                              : acc[n] + {{(COUNT_WIDTH-1){1'b0}}, scaler_i[n]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_SCALERS; n++) begin
        acc[n]     <= '0;
        holding[n] <= '0;
      end
      sat        <= '0;
      overflow_o <= '0;
    end else begin
      for (int n = 0; n < NUM_SCALERS; n++) begin
        if (acc_clr) begin
          acc[n] <= '0;
        end else if (acc_run) begin
          acc[n] <= acc_inc[n];
        end

        if (clear_i) begin
          holding[n] <= '0;
        end else if (latch_en) begin
          holding[n] <= acc_inc[n];
        end
      end

      if (acc_clr) begin
        sat <= '0;
      end else if (acc_run) begin
        sat <= sat | sat_hit;
      end

      if (clear_i) begin
        overflow_o <= '0;
      end else if (latch_en) begin
        overflow_o <= sat | sat_hit;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      update_o       <= 1'b0;
      period_count_o <= 8'd0;
    end else begin
      update_o <= latch_en;
      if (clear_i) begin
        period_count_o <= 8'd0;
      end else if (latch_en) begin
        period_count_o <= period_count_o + 8'd1;
      end
    end
  end

  // Holding registers update on the same edge, so a coincident read sees the pre-latch value.
  always_comb begin
    rd_sel = '0;
    if (int'(rd_addr_i) < NUM_SCALERS) begin
      rd_sel = holding[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_i;
      if (rd_i) begin
        rd_data_o <= rd_sel;
      end
    end
  end

endmodule

`default_nettype wire
